cosim_perf_counters: RTL and testbench
======================================

Name: cosim_perf_counters

Overview:
- Parametrised successor to the single cycle counter for cosimulated designs.
- Holds a free-running cycle counter and NUM_COUNTERS event counters, each with a sticky overflow flag.
- The host issues opcode requests over a valid/ready channel and gets back a registered response: cycle, selected counter, flags and clock frequency.
- Sits between design event strobes and the cosim FromHost/ToHost endpoints; one instance per design.

Parameters:
- NUM_COUNTERS, 4: number of event counters (1..256).
- COUNTER_WIDTH, 64: width of the cycle counter and each event counter (8..64).
- CORE_CLOCK_FREQUENCY_HZ, 100_000_000: constant returned in every response (64-bit).
- SATURATE, 0: 0 means event counters wrap to 0; 1 means they hold at all-ones. The cycle counter always wraps.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active-low.
- event_inc  in  NUM_COUNTERS  per-counter increment strobe; one count per cycle when high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_op  in  2  opcode: 0 READ, 1 READ_CLEAR, 2 CLEAR_ALL, 3 SET_ENABLE.
- req_index  in  8  counter index for READ and READ_CLEAR.
- req_arg  in  NUM_COUNTERS  enable mask for SET_ENABLE.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response ready.
- resp_cycle  out  64  cycle count, zero-extended.
- resp_count  out  64  selected counter value, zero-extended.
- resp_freq  out  64  CORE_CLOCK_FREQUENCY_HZ.
- resp_status  out  2  bit0 ERR (bad index), bit1 OVF (selected counter's sticky overflow).

Behaviour:
- Reset (rst_n low at a clk edge):
  - all counters, overflow flags and resp_* data go to 0; resp_valid=0.
  - enable mask goes to all-ones.
  - req_ready is low while rst_n is low.
  - a pending response is discarded.
- Cycle counter: increments every non-reset cycle; wraps at 2^COUNTER_WIDTH.
- Event counter i increments when event_inc[i] & enable[i].
  - At all-ones with an increment: set ovf[i]=1. Then wrap to 0 (SATURATE=0) or hold (SATURATE=1).
- Request is accepted when req_valid & req_ready.
  - req_ready = !resp_valid | resp_ready. This is a single-entry output register with no bubble on back-to-back requests.
- Response latency: resp_valid rises the cycle after acceptance. Data is held stable until resp_ready.
- Sampling: resp_cycle and resp_count capture pre-edge values at the accept edge, i.e. they do not include that cycle's increment.
- READ: returns counter[req_index] and ovf[req_index]; no state change.
- READ_CLEAR: returns as READ. Same edge clears ovf[idx] and sets counter[idx] = (event_inc[idx] & enable[idx]) ? 1 : 0, so no event is lost.
- CLEAR_ALL:
  - all event counters and ovf flags are cleared; increments in the same cycle are applied after the clear, giving 0 or 1.
  - the cycle counter is not cleared.
  - resp_count=0, resp_status=0.
- SET_ENABLE: enable <= req_arg from the next cycle. The response returns the cycle count and resp_count=0.
- Index out of range (req_index >= NUM_COUNTERS) for READ/READ_CLEAR: resp_count=0, ERR=1, no state change.
- req_index is ignored for CLEAR_ALL and SET_ENABLE.
- resp_freq is constant.
- Unused high bits of req_index are compared in full; no truncation aliasing.
- Reset mid-handshake: the response is dropped and the request is not consumed.

Test Plan:
- Reset released at cycle 0; READ idx 0 accepted at cycle 10 with no events -> next cycle resp_valid=1, resp_cycle=10, resp_count=0, resp_status=0, resp_freq=100_000_000.
- event_inc[1] high for 5 cycles; READ idx 1 -> resp_count=5. Then READ_CLEAR with event_inc[1] high on the accept edge -> resp_count=5, and a following READ returns 1.
- COUNTER_WIDTH=8, SATURATE=0: 257 events on counter 2 -> READ gives count=1, OVF=1. READ_CLEAR then READ -> OVF=0. Repeat with SATURATE=1 -> count=255, OVF=1.
- resp_ready held low for 4 cycles with req_valid high -> req_ready=0, response stable. resp_ready high for 3 cycles with requests back-to-back -> 3 responses on consecutive cycles.
- READ idx 7 with NUM_COUNTERS=4 -> ERR=1, count=0. SET_ENABLE arg=4'b0001, then events on all lines for 3 cycles -> counter0 +3, counters 1-3 unchanged.
- rst_n low while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, all counters 0, enable all-ones.

Source files
------------

// File: rtl/cosim_perf_counters.sv
// Cosim performance counters: a free-running cycle counter plus NUM_COUNTERS gated
// event counters with sticky overflow, queried through a valid/ready opcode channel.
module cosim_perf_counters #(
  parameter int unsigned NUM_COUNTERS            = 4,
  parameter int unsigned COUNTER_WIDTH           = 64,
  parameter logic [63:0] CORE_CLOCK_FREQUENCY_HZ = 64'd100_000_000,
  parameter bit          SATURATE                = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_COUNTERS-1:0] event_inc,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [7:0]              req_index,
  input  logic [NUM_COUNTERS-1:0] req_arg,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [63:0]             resp_cycle,
  output logic [63:0]             resp_count,
  output logic [63:0]             resp_freq,
  output logic [1:0]              resp_status
);

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_READ_CLEAR = 2'd1,
    OP_CLEAR_ALL  = 2'd2,
    OP_SET_ENABLE = 2'd3
  } op_e;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  op_e                      op;
  logic                     accept;
  logic                     idx_ok;
  logic                     is_read;
  logic [COUNTER_WIDTH-1:0] cycle_cnt;
  logic [COUNTER_WIDTH-1:0] cnt     [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_nxt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  ovf;
  logic [NUM_COUNTERS-1:0]  ovf_nxt;
  logic [NUM_COUNTERS-1:0]  enable;
  logic [NUM_COUNTERS-1:0]  inc_vec;
  logic [NUM_COUNTERS-1:0]  clr_vec;
  logic [COUNTER_WIDTH-1:0] sel_cnt;
  logic                     sel_ovf;

  assign op        = op_e'(req_op);
  assign req_ready = rst_n & (~resp_valid | resp_ready);
  assign accept    = req_valid & req_ready;
  // Full 8-bit compare so out-of-range indices never alias onto a real counter.
  assign idx_ok    = 32'(req_index) < NUM_COUNTERS;
  assign is_read   = (op == OP_READ) || (op == OP_READ_CLEAR);
  assign inc_vec   = event_inc & enable;
  assign resp_freq = CORE_CLOCK_FREQUENCY_HZ;

  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (32'(req_index) == i) begin
        sel_cnt = cnt[i];
        sel_ovf = ovf[i];
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      clr_vec[i] = accept && ((op == OP_CLEAR_ALL) ||
                              ((op == OP_READ_CLEAR) && (32'(req_index) == i)));
    end
  end

  // A clear still honours the same-cycle increment, so no event is lost.
  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      cnt_nxt[i] = cnt[i];
      ovf_nxt[i] = ovf[i];
      if (clr_vec[i]) begin
        cnt_nxt[i] = inc_vec[i] ? CNT_ONE : '0;
        ovf_nxt[i] = 1'b0;
      end else if (inc_vec[i]) begin
        if (&cnt[i]) begin
          ovf_nxt[i] = 1'b1;
          cnt_nxt[i] = SATURATE ? cnt[i] : '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      ovf       <= '0;
      enable    <= '1;
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt[i] <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      ovf       <= ovf_nxt;
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt[i] <= cnt_nxt[i];
      if (accept && (op == OP_SET_ENABLE)) enable <= req_arg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_cycle  <= '0;
      resp_count  <= '0;
      resp_status <= '0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_cycle  <= 64'(cycle_cnt);
      resp_count  <= '0;
      resp_status <= '0;
      if (is_read) begin
        if (idx_ok) begin
          resp_count  <= 64'(sel_cnt);
          resp_status <= {sel_ovf, 1'b0};
        end else begin
          resp_status <= 2'b01;
        end
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cosim_perf_counters.sv
// Scoreboard bench: a wrapping and a saturating 8-bit instance share stimulus and
// are checked against a behavioural model of counters and the response handshake.
module tb_cosim_perf_counters;
  localparam int unsigned NC   = 4;
  localparam longint      FREQ = 100_000_000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] ev;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [7:0]    req_index;
  logic [NC-1:0] req_arg;
  logic          resp_ready;

  logic        rr0, rv0, rr1, rv1;
  logic [63:0] cyc0, cnt0, frq0, cyc1, cnt1, frq1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  cosim_perf_counters #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(8), .SATURATE(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .event_inc(ev), .req_valid(req_valid), .req_ready(rr0),
    .req_op(req_op), .req_index(req_index), .req_arg(req_arg), .resp_valid(rv0),
    .resp_ready(resp_ready), .resp_cycle(cyc0), .resp_count(cnt0), .resp_freq(frq0),
    .resp_status(st0));

  cosim_perf_counters #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(8), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .event_inc(ev), .req_valid(req_valid), .req_ready(rr1),
    .req_op(req_op), .req_index(req_index), .req_arg(req_arg), .resp_valid(rv1),
    .resp_ready(resp_ready), .resp_cycle(cyc1), .resp_count(cnt1), .resp_freq(frq1),
    .resp_status(st1));

  typedef struct {
    logic [63:0] cyc;
    logic [63:0] c0;
    logic [63:0] c1;
    logic [1:0]  s0;
    logic [1:0]  s1;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur;
  int     errors = 0;
  int     checks = 0;
  int     m_cnt [2][NC];
  bit     m_ovf [2][NC];
  bit [NC-1:0] m_en;
  int     m_cycle;
  bit     m_rv;
  bit     acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(output bit accepted);
    exp_t e;
    bit   inc, clr, exp_rdy;
    #1;
    exp_rdy = rst_n & (!m_rv | resp_ready);
    check("req_ready0", rr0, exp_rdy);
    check("req_ready1", rr1, exp_rdy);
    accepted = req_valid & exp_rdy;
    if (accepted) begin
      e.cyc = m_cycle; e.c0 = 0; e.c1 = 0; e.s0 = 0; e.s1 = 0;
      if (req_op <= 2'd1) begin
        if (req_index < NC) begin
          e.c0 = m_cnt[0][req_index]; e.s0 = {m_ovf[0][req_index], 1'b0};
          e.c1 = m_cnt[1][req_index]; e.s1 = {m_ovf[1][req_index], 1'b0};
        end else begin
          e.s0 = 2'b01; e.s1 = 2'b01;
        end
      end
      sb.push_back(e);
    end
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NC; i++) begin m_cnt[k][i] = 0; m_ovf[k][i] = 0; end
      m_en = '1; m_cycle = 0; m_rv = 0;
      sb.delete();
    end else begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NC; i++) begin
          inc = ev[i] & m_en[i];
          clr = accepted && (req_op == 2'd2 || (req_op == 2'd1 && req_index == i));
          if (clr) begin
            m_cnt[k][i] = inc ? 1 : 0; m_ovf[k][i] = 0;
          end else if (inc) begin
            if (m_cnt[k][i] == 255) begin
              m_ovf[k][i] = 1; m_cnt[k][i] = (k == 1) ? 255 : 0;
            end else m_cnt[k][i]++;
          end
        end
      if (accepted && req_op == 2'd3) m_en = req_arg;
      m_cycle = (m_cycle + 1) % 256;
      m_rv = accepted ? 1'b1 : (resp_ready ? 1'b0 : m_rv);
    end
    @(posedge clk); #1;
    if (accepted && sb.size() > 0) cur = sb.pop_front();
    check("resp_valid0", rv0, m_rv);
    check("resp_valid1", rv1, m_rv);
    if (m_rv) begin
      check("resp_cycle0", cyc0, cur.cyc);
      check("resp_cycle1", cyc1, cur.cyc);
      check("resp_count0", cnt0, cur.c0);
      check("resp_count1", cnt1, cur.c1);
      check("resp_status0", st0, cur.s0);
      check("resp_status1", st1, cur.s1);
      check("resp_freq0", frq0, FREQ);
      check("resp_freq1", frq1, FREQ);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [7:0] idx, input logic [NC-1:0] arg);
    bit a;
    req_valid = 1'b1; req_op = op; req_index = idx; req_arg = arg;
    a = 1'b0;
    for (int n = 0; n < 20 && !a; n++) tick(a);
    if (!a) check("req_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int j = 0; j < n; j++) tick(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ev = '0; req_valid = 1'b0; req_op = '0; req_index = '0;
    req_arg = '0; resp_ready = 1'b1;
    idle(3);
    check("rst_valid", rv0, 0);
    check("rst_count", cnt0, 0);
    check("rst_cycle", cyc0, 0);
    check("rst_status", st0, 0);

    rst_n = 1'b1;
    idle(10);
    req(2'd0, 8'd0, '0);
    check("first_cycle", cyc0, 10);
    check("first_count", cnt0, 0);
    check("first_freq", frq0, FREQ);

    ev = 4'b0010; idle(5); ev = '0;
    req(2'd0, 8'd1, '0);
    check("read1_5", cnt0, 5);
    ev = 4'b0010;
    req(2'd1, 8'd1, '0);
    ev = '0;
    check("rdclr1_5", cnt0, 5);
    req(2'd0, 8'd1, '0);
    check("after_clr_1", cnt0, 1);

    ev = 4'b0100; idle(257); ev = '0;
    req(2'd0, 8'd2, '0);
    check("wrap_count", cnt0, 1);
    check("wrap_ovf", st0, 2'b10);
    check("sat_count", cnt1, 255);
    check("sat_ovf", st1, 2'b10);
    req(2'd1, 8'd2, '0);
    req(2'd0, 8'd2, '0);
    check("ovf_cleared0", st0, 0);
    check("ovf_cleared1", st1, 0);

    // Hold the previous response under backpressure, then stream three requests.
    resp_ready = 1'b0; req_valid = 1'b1; req_op = 2'd0; req_index = 8'd3;
    idle(4);
    check("bp_ready", rr0, 0);
    resp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      req_index = 8'(j);
      tick(acc);
      check("b2b_accept", acc, 1);
      check("b2b_valid", rv0, 1);
    end
    req_valid = 1'b0;
    idle(1);

    req(2'd0, 8'd7, '0);
    check("bad_idx_err", st0, 2'b01);
    check("bad_idx_cnt", cnt0, 0);
    req(2'd0, 8'd4, '0);
    check("idx4_err", st0, 2'b01);
    req(2'd1, 8'd200, '0);
    check("idx200_err", st0, 2'b01);

    req(2'd3, 8'd9, 4'b0001);
    ev = 4'b1111; idle(3); ev = '0;
    for (int i = 0; i < NC; i++) req(2'd0, 8'(i), '0);
    ev = 4'b1111;
    req(2'd2, 8'd0, '0);
    ev = '0;
    check("clrall_count", cnt0, 0);
    req(2'd0, 8'd0, '0);
    check("clrall_inc0", cnt0, 1);
    req(2'd0, 8'd1, '0);
    check("clrall_gated1", cnt0, 0);

    // Reset while a response is stalled: it must be dropped, state back to defaults.
    req(2'd3, 8'd0, 4'b1111);
    ev = 4'b1010; idle(2); ev = '0;
    resp_ready = 1'b0;
    req(2'd0, 8'd1, '0);
    req_valid = 1'b1;
    rst_n = 1'b0;
    idle(1);
    check("midrst_valid", rv0, 0);
    rst_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    idle(1);
    for (int i = 0; i < NC; i++) begin
      req(2'd0, 8'(i), '0);
      check("midrst_zero", cnt0, 0);
    end
    ev = 4'b1111; idle(1); ev = '0;
    for (int i = 0; i < NC; i++) begin
      req(2'd0, 8'(i), '0);
      check("midrst_enabled", cnt0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
